// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap/exception sequencer of the multicycle core.
//   - trap_state_e      : sequencer states (IDLE, FETCH, LOAD)
//   - CAUSE_*           : cause line indices, bit 0 = highest priority
//   - TRAP_DEF_VEC_BASE : default data address of the cause-0 vector entry
//   - trap_idx_w()      : width of an index over n items (never below 1 bit)
// No ports (package).
// -----------------------------------------------------------------------------
package trap_pkg;

    typedef enum logic [1:0] {
        TRAP_IDLE  = 2'd0,
        TRAP_FETCH = 2'd1,
        TRAP_LOAD  = 2'd2
    } trap_state_e;

    localparam int CAUSE_ALU_OVERFLOW = 0;
    localparam int CAUSE_ILLEGAL_OP   = 1;
    localparam int CAUSE_MISALIGNED   = 2;
    localparam int CAUSE_SW           = 3;

    localparam int TRAP_DEF_VEC_BASE  = 254;

    // Index width for n items; a single item still needs a 1-bit field.
    function automatic int trap_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_prio_enc
// Combinational lowest-index-first priority encoder for cause requests.
// Ports:
//   i_req   [N-1:0]  request lines, bit 0 = highest priority
//   o_idx   [IW-1:0] index of the lowest set request (0 when none)
//   o_valid          at least one request is set
// -----------------------------------------------------------------------------
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                i_req,
    output logic [trap_idx_w(N)-1:0]    o_idx,
    output logic                        o_valid
);

    localparam int IW = trap_idx_w(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = N - 1; i >= 0; i--) begin
            o_idx = i_req[i] ? IW'(i) : o_idx;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
// Multicycle trap sequencer: on an accepted cause it saves EPC/cause, reads the
// handler address from a vector table in data memory (fixed read latency) and
// issues a one-cycle PC load. Also services trap-return (PC <- EPC).
// Optional build macro: TRAP_NEST_GUARD_EN (adds o_double_fault; a cause taken
// while still inside a handler is refused and flagged as a sticky double fault).
// Ports:
//   i_clk, i_reset      clock (rising edge), synchronous active-high reset
//   i_cause_req         level cause requests, bit 0 = highest priority
//   i_trap_en           control FSM cycle in which a cause may be accepted
//   i_faulting_pc       PC of the excepting instruction
//   i_trap_return       one-cycle request to resume at EPC
//   o_mem_rd, o_mem_addr  vector read request and entry address
//   i_mem_rdata         data-memory read data
//   o_epc, o_cause      saved exception PC and index of last accepted cause
//   o_trap_busy         sequencer active; control FSM holds
//   o_pc_load, o_pc_value one-cycle PC write strobe and its value
//   o_double_fault      (TRAP_NEST_GUARD_EN only) sticky nested-cause flag
// -----------------------------------------------------------------------------
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NUM_CAUSES = 4,
    parameter int VEC_BASE   = TRAP_DEF_VEC_BASE,
    parameter int VEC_STRIDE = 1,
    parameter int VEC_W      = 8,
    parameter int MEM_LAT    = 1
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [NUM_CAUSES-1:0]               i_cause_req,
    input  logic                                i_trap_en,
    input  logic [XLEN-1:0]                     i_faulting_pc,
    input  logic                                i_trap_return,
    output logic                                o_mem_rd,
    output logic [XLEN-1:0]                     o_mem_addr,
    input  logic [XLEN-1:0]                     i_mem_rdata,
    output logic [XLEN-1:0]                     o_epc,
    output logic [trap_idx_w(NUM_CAUSES)-1:0]   o_cause,
    output logic                                o_trap_busy,
    output logic                                o_pc_load,
`ifdef TRAP_NEST_GUARD_EN
    output logic                                o_double_fault,
`endif
    output logic [XLEN-1:0]                     o_pc_value
);

    localparam int CW    = trap_idx_w(NUM_CAUSES);
    localparam int CNT_W = trap_idx_w(MEM_LAT + 1);

    localparam logic [1:0] ST_IDLE  = TRAP_IDLE;
    localparam logic [1:0] ST_FETCH = TRAP_FETCH;
    localparam logic [1:0] ST_LOAD  = TRAP_LOAD;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  BASE_X   = XLEN'(VEC_BASE);
    localparam logic [XLEN-1:0]  STRIDE_X = XLEN'(VEC_STRIDE);

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_count;
    logic            r_mem_rd;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_epc;
    logic [CW-1:0]   r_cause;
    logic            r_trap_busy;
    logic            r_pc_load;
    logic [XLEN-1:0] r_pc_value;

    logic [CW-1:0]   w_idx;
    logic            w_valid;
    logic            w_cause_seen;
    logic            w_take_cause;
    logic [XLEN-1:0] w_vec_addr;
    logic [XLEN-1:0] w_handler;
    logic            w_unused_rdata;

    trap_prio_enc #(
        .N (NUM_CAUSES)
    ) u_prio_enc (
        .i_req   (i_cause_req),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_cause_seen = i_trap_en & w_valid;

    // Vector entry address; XLEN arithmetic so it wraps naturally.
    assign w_vec_addr   = BASE_X + (XLEN'(w_idx) * STRIDE_X);

    // Only the low VEC_W bits of an entry form the handler address.
    assign w_handler      = XLEN'(i_mem_rdata[VEC_W-1:0]);
    assign w_unused_rdata = ^i_mem_rdata;

`ifdef TRAP_NEST_GUARD_EN
    logic r_in_handler;
    logic r_double_fault;

    assign w_take_cause   = w_cause_seen & ~r_in_handler;
    assign o_double_fault = r_double_fault;

    // Track handler residency; a cause arriving inside a handler is a double fault.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_in_handler   <= 1'b0;
            r_double_fault <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_take_cause) begin
                r_in_handler <= 1'b1;
            end else if (i_trap_return) begin
                r_in_handler <= 1'b0;
            end
            if (w_cause_seen && r_in_handler) begin
                r_double_fault <= 1'b1;
            end
        end
    end
`else
    assign w_take_cause = w_cause_seen;
`endif

    // Sequencer FSM and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_epc       <= '0;
            r_cause     <= '0;
            r_trap_busy <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_value  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A cause wins over a simultaneous trap-return.
                    if (w_take_cause) begin
                        r_epc       <= i_faulting_pc;
                        r_cause     <= w_idx;
                        r_mem_addr  <= w_vec_addr;
                        r_mem_rd    <= 1'b1;
                        r_trap_busy <= 1'b1;
                        r_count     <= CNT_INIT;
                        r_state     <= ST_FETCH;
                    end else if (i_trap_return) begin
                        r_pc_value  <= r_epc;
                        r_pc_load   <= 1'b1;
                        r_trap_busy <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_FETCH: begin
                    // Read data is valid on the edge where the countdown reaches 1.
                    if (r_count == CNT_ONE) begin
                        r_pc_value <= w_handler;
                        r_pc_load  <= 1'b1;
                        r_mem_rd   <= 1'b0;
                        r_state    <= ST_LOAD;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    r_pc_load   <= 1'b0;
                    r_trap_busy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_mem_rd    <= 1'b0;
                    r_pc_load   <= 1'b0;
                    r_trap_busy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_rd    = r_mem_rd;
    assign o_mem_addr  = r_mem_addr;
    assign o_epc       = r_epc;
    assign o_cause     = r_cause;
    assign o_trap_busy = r_trap_busy;
    assign o_pc_load   = r_pc_load;
    assign o_pc_value  = r_pc_value;

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
// Directed bench for trap_controller. Two instances share every input:
//   dut_a : default parameters (VEC_STRIDE=1, MEM_LAT=1)
//   dut_b : VEC_STRIDE=8, MEM_LAT=3
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cause_req;
    logic        trap_en;
    logic        trap_return;
    logic [63:0] fpc;
    logic [63:0] rdata;

    logic        a_rd, a_busy, a_load;
    logic [63:0] a_addr, a_epc, a_pcv;
    logic [1:0]  a_cause;
    logic        b_rd, b_busy, b_load;
    logic [63:0] b_addr, b_epc, b_pcv;
    logic [1:0]  b_cause;
`ifdef TRAP_NEST_GUARD_EN
    logic        a_df, b_df;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Per-window observation counters (window starts at the first sample after acceptance).
    int          win_idx;
    int          a_rd_n, a_busy_n, a_load_n, a_load_at;
    int          b_rd_n, b_busy_n, b_load_n, b_load_at;
    logic [63:0] a_load_val, b_load_val;

    always #5 clk = ~clk;

    trap_controller dut_a (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cause_req   (cause_req),
        .i_trap_en     (trap_en),
        .i_faulting_pc (fpc),
        .i_trap_return (trap_return),
        .o_mem_rd      (a_rd),
        .o_mem_addr    (a_addr),
        .i_mem_rdata   (rdata),
        .o_epc         (a_epc),
        .o_cause       (a_cause),
        .o_trap_busy   (a_busy),
        .o_pc_load     (a_load),
`ifdef TRAP_NEST_GUARD_EN
        .o_double_fault(a_df),
`endif
        .o_pc_value    (a_pcv)
    );

    trap_controller #(
        .VEC_STRIDE (8),
        .MEM_LAT    (3)
    ) dut_b (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cause_req   (cause_req),
        .i_trap_en     (trap_en),
        .i_faulting_pc (fpc),
        .i_trap_return (trap_return),
        .o_mem_rd      (b_rd),
        .o_mem_addr    (b_addr),
        .i_mem_rdata   (rdata),
        .o_epc         (b_epc),
        .o_cause       (b_cause),
        .o_trap_busy   (b_busy),
        .o_pc_load     (b_load),
`ifdef TRAP_NEST_GUARD_EN
        .o_double_fault(b_df),
`endif
        .o_pc_value    (b_pcv)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_win();
        win_idx   = 0;
        a_rd_n    = 0; a_busy_n = 0; a_load_n = 0; a_load_at = -1; a_load_val = '0;
        b_rd_n    = 0; b_busy_n = 0; b_load_n = 0; b_load_at = -1; b_load_val = '0;
    endtask

    task automatic sample();
        if (a_rd)   a_rd_n++;
        if (a_busy) a_busy_n++;
        if (a_load) begin
            a_load_n++;
            if (a_load_at < 0) a_load_at = win_idx;
            a_load_val = a_pcv;
        end
        if (b_rd)   b_rd_n++;
        if (b_busy) b_busy_n++;
        if (b_load) begin
            b_load_n++;
            if (b_load_at < 0) b_load_at = win_idx;
            b_load_val = b_pcv;
        end
        win_idx++;
    endtask

    task automatic step();
        tick();
        sample();
    endtask

    // Present a request for one edge, then drop it and open a fresh window.
    task automatic fire(input logic [3:0] cr, input logic te, input logic tr, input logic [63:0] pc);
        cause_req   = cr;
        trap_en     = te;
        trap_return = tr;
        fpc         = pc;
        tick();
        cause_req   = 4'd0;
        trap_en     = 1'b0;
        trap_return = 1'b0;
        clear_win();
        sample();
    endtask

    task automatic do_return();
        fire(4'd0, 1'b0, 1'b1, 64'd0);
        repeat (3) step();
    endtask

    initial begin
        logic [63:0] vals [6];
        vals[0] = 64'hAB11; vals[1] = 64'hCD22; vals[2] = 64'hEF33;
        vals[3] = 64'h0044; vals[4] = 64'h0055; vals[5] = 64'h0066;

        reset = 1'b1; cause_req = 4'd0; trap_en = 1'b0; trap_return = 1'b0;
        fpc = 64'd0; rdata = 64'd0;
        repeat (2) tick();
        check("rst_a_busy",  {63'd0, a_busy}, 64'd0);
        check("rst_a_load",  {63'd0, a_load}, 64'd0);
        check("rst_a_rd",    {63'd0, a_rd},   64'd0);
        check("rst_a_epc",   a_epc,           64'd0);
        check("rst_a_cause", {62'd0, a_cause}, 64'd0);
        check("rst_a_pcv",   a_pcv,           64'd0);
        check("rst_a_addr",  a_addr,          64'd0);
        check("rst_b_busy",  {63'd0, b_busy}, 64'd0);
        reset = 1'b0;
        tick();

        // Overflow trap with default table.
        rdata = 64'h1234;
        fire(4'b0001, 1'b1, 1'b0, 64'h40);
        check("t1_a_rd",    {63'd0, a_rd},    64'd1);
        check("t1_a_addr",  a_addr,           64'd254);
        check("t1_a_epc",   a_epc,            64'h40);
        check("t1_a_cause", {62'd0, a_cause}, 64'd0);
        check("t1_a_busy",  {63'd0, a_busy},  64'd1);
        check("t1_a_load0", {63'd0, a_load},  64'd0);
        check("t1_b_addr",  b_addr,           64'd254);
        repeat (6) step();
        check("t1_a_rd_n",   a_rd_n,     64'd1);
        check("t1_a_busy_n", a_busy_n,   64'd2);
        check("t1_a_load_n", a_load_n,   64'd1);
        check("t1_a_load_at", a_load_at, 64'd1);
        check("t1_a_pcv",    a_load_val, 64'h34);
        check("t1_b_rd_n",   b_rd_n,     64'd3);
        check("t1_b_busy_n", b_busy_n,   64'd4);
        check("t1_b_load_at", b_load_at, 64'd3);
        check("t1_b_pcv",    b_load_val, 64'h34);

        // Trap return resumes at EPC, one busy cycle, EPC/cause untouched.
        fire(4'd0, 1'b0, 1'b1, 64'd0);
        check("ret_a_load", {63'd0, a_load}, 64'd1);
        check("ret_a_pcv",  a_pcv,           64'h40);
        repeat (3) step();
        check("ret_a_load_n", a_load_n, 64'd1);
        check("ret_a_busy_n", a_busy_n, 64'd1);
        check("ret_a_rd_n",   a_rd_n,   64'd0);
        check("ret_a_epc",    a_epc,    64'h40);

        // Causes without trap_en are ignored.
        cause_req = 4'b0001;
        repeat (2) tick();
        check("noen_a_busy", {63'd0, a_busy}, 64'd0);
        check("noen_b_rd",   {63'd0, b_rd},   64'd0);
        cause_req = 4'd0;

        // Priority: lowest set bit wins.
        fire(4'b0110, 1'b1, 1'b0, 64'h88);
        check("pri_a_cause", {62'd0, a_cause}, 64'd1);
        check("pri_a_addr",  a_addr,           64'd255);
        check("pri_b_addr",  b_addr,           64'd262);
        check("pri_a_epc",   a_epc,            64'h88);
        repeat (6) step();
        fire(4'd0, 1'b0, 1'b1, 64'd0);
        repeat (3) step();
        check("pri_ret_pcv", a_load_val, 64'h88);

        // Stride 8, cause 3; read data changes every cycle during the fetch.
        fire(4'b1000, 1'b1, 1'b0, 64'h90);
        check("str_b_addr",  b_addr,           64'd278);
        check("str_b_cause", {62'd0, b_cause}, 64'd3);
        check("str_a_addr",  a_addr,           64'd257);
        for (int i = 0; i < 6; i++) begin
            rdata = vals[i];
            step();
        end
        check("lat_a_pcv",    a_load_val, 64'h11);
        check("lat_b_pcv",    b_load_val, 64'h33);
        check("lat_b_rd_n",   b_rd_n,     64'd3);
        check("lat_b_load_n", b_load_n,   64'd1);
        check("lat_b_load_at", b_load_at, 64'd3);
        do_return();
        check("lat_b_ret_pcv", b_load_val, 64'h90);

        // Cause and trap_return together: the trap is taken.
        rdata = 64'h5A;
        fire(4'b0001, 1'b1, 1'b1, 64'h300);
        check("col_a_load0", {63'd0, a_load}, 64'd0);
        check("col_a_rd",    {63'd0, a_rd},   64'd1);
        check("col_a_epc",   a_epc,           64'h300);
        repeat (6) step();
        check("col_a_load_n",  a_load_n,   64'd1);
        check("col_a_load_at", a_load_at,  64'd1);
        check("col_a_pcv",     a_load_val, 64'h5A);
        do_return();

        // Reset during the second fetch cycle of dut_b.
        fire(4'b0010, 1'b1, 1'b0, 64'h400);
        step();
        reset = 1'b1;
        step();
        check("rstf_b_rd",    {63'd0, b_rd},    64'd0);
        check("rstf_b_busy",  {63'd0, b_busy},  64'd0);
        check("rstf_b_load",  {63'd0, b_load},  64'd0);
        check("rstf_b_epc",   b_epc,            64'd0);
        check("rstf_b_cause", {62'd0, b_cause}, 64'd0);
        check("rstf_b_addr",  b_addr,           64'd0);
        check("rstf_b_pcv",   b_pcv,            64'd0);
        reset = 1'b0;
        repeat (5) step();
        check("rstf_b_load_n", b_load_n, 64'd0);

`ifdef TRAP_NEST_GUARD_EN
        fire(4'b0001, 1'b1, 1'b0, 64'h500);
        repeat (6) step();
        check("ng_a_df0", {63'd0, a_df}, 64'd0);
        fire(4'b0010, 1'b1, 1'b0, 64'h600);
        check("ng_a_df",    {63'd0, a_df},    64'd1);
        check("ng_a_epc",   a_epc,            64'h500);
        check("ng_a_cause", {62'd0, a_cause}, 64'd0);
        check("ng_a_rd",    {63'd0, a_rd},    64'd0);
        check("ng_a_busy",  {63'd0, a_busy},  64'd0);
        do_return();
        fire(4'b0100, 1'b1, 1'b0, 64'h700);
        check("ng_new_rd",    {63'd0, a_rd},    64'd1);
        check("ng_new_epc",   a_epc,            64'h700);
        check("ng_new_cause", {62'd0, a_cause}, 64'd2);
        check("ng_df_sticky", {63'd0, a_df},    64'd1);
        repeat (6) step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
